// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 width codes,
// FSM state encoding and wait-counter width.
package lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for RV32I accesses: byte enables, store replication,
// load extraction/extension and the alignment/legality check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic            is_store,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [3:0]      be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] load_c,
  output logic            misaligned_c
);

  logic [15:0] lane;

  always_comb begin
    be_c         = 4'b0000;
    wdata_c      = wdata;
    load_c       = mem_rdata;
    misaligned_c = 1'b0;
    lane         = 16'(mem_rdata >> {addr_lo, 3'b000});
    case (funct3)
      F3_B: begin
        be_c    = 4'b0001 << addr_lo;
        wdata_c = {4{wdata[7:0]}};
        load_c  = {{24{lane[7]}}, lane[7:0]};
      end
      F3_BU: begin
        be_c         = 4'b0001 << addr_lo;
        wdata_c      = {4{wdata[7:0]}};
        load_c       = {24'h0, lane[7:0]};
        misaligned_c = is_store;
      end
      F3_H: begin
        be_c         = 4'b0011 << addr_lo;
        wdata_c      = {2{wdata[15:0]}};
        load_c       = {{16{lane[15]}}, lane[15:0]};
        misaligned_c = addr_lo[0];
      end
      F3_HU: begin
        be_c         = 4'b0011 << addr_lo;
        wdata_c      = {2{wdata[15:0]}};
        load_c       = {16'h0, lane[15:0]};
        misaligned_c = addr_lo[0] | is_store;
      end
      F3_W: begin
        be_c         = 4'b1111;
        misaligned_c = |addr_lo;
      end
      default: misaligned_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: IDLE -> BUS -> DONE handshake
// with a bounded wait for mem_ack and registered bus/result outputs.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            misaligned,
  output logic            bus_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  lsu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic            is_store_q, is_store_d;

  logic            busy_d, done_d, misaligned_d, bus_err_d;
  logic            mem_req_d, mem_we_d;
  logic [XLEN-1:0] rdata_d, mem_addr_d, mem_wdata_d;
  logic [3:0]      mem_be_d;

  logic [2:0]      al_funct3;
  logic [1:0]      al_addr_lo;
  logic            al_is_store;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c, load_c;
  logic            misaligned_c;

  // In IDLE the aligner sees the live request; afterwards the captured one.
  assign al_funct3   = (state_q == IDLE) ? funct3   : funct3_q;
  assign al_addr_lo  = (state_q == IDLE) ? addr[1:0] : addr_lo_q;
  assign al_is_store = (state_q == IDLE) ? is_store : is_store_q;

  lsu_align u_align (
    .funct3       (al_funct3),
    .addr_lo      (al_addr_lo),
    .is_store     (al_is_store),
    .wdata        (wdata),
    .mem_rdata    (mem_rdata),
    .be_c         (be_c),
    .wdata_c      (wdata_c),
    .load_c       (load_c),
    .misaligned_c (misaligned_c)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    is_store_d   = is_store_q;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    rdata_d      = rdata;
    mem_addr_d   = mem_addr;
    mem_be_d     = mem_be;
    mem_wdata_d  = mem_wdata;
    case (state_q)
      IDLE: begin
        if (start) begin
          funct3_d    = funct3;
          addr_lo_d   = addr[1:0];
          is_store_d  = is_store;
          cnt_d       = '0;
          mem_addr_d  = {addr[XLEN-1:2], 2'b00};
          mem_be_d    = be_c;
          mem_wdata_d = wdata_c;
          if (misaligned_c) begin
            state_d      = DONE;
            misaligned_d = 1'b1;
          end else begin
            state_d   = BUS;
            mem_req_d = 1'b1;
            mem_we_d  = is_store;
          end
        end
      end
      BUS: begin
        if (mem_ack) begin
          if (!is_store_q) rdata_d = load_c;
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      is_store_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      is_store_q <= is_store_d;
      busy       <= busy_d;
      done       <= done_d;
      rdata      <= rdata_d;
      misaligned <= misaligned_d;
      bus_err    <= bus_err_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_be     <= mem_be_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule
